// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decodes the ID instruction, detects load-use
// and mult/div hazards, and registers the control bundle into EX.
module pipe_ctrl_unit #(
    parameter int MULDIV_LAT    = 4,
    parameter bit ENABLE_MULDIV = 1'b1,
    parameter int REG_AW        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [5:0]        OpCode,
    input  logic [5:0]        Funct,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc1,
    output logic              ex_ALUSrc2,
    output logic              ex_ExtOp,
    output logic              ex_LuOp,
    output logic              ex_LbOp,
    output logic              ex_Branch,
    output logic              ex_EqualOp,
    output logic [1:0]        ex_PCSrc,
    output logic [1:0]        ex_MemtoReg,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_muldiv_start,
    output logic [1:0]        ex_hilo_sel,
    output logic              ex_illegal,
    output logic              muldiv_busy
);

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc1;
        logic       aluSrc2;
        logic       extOp;
        logic       luOp;
        logic       lbOp;
        logic       branch;
        logic       equalOp;
        logic [1:0] pcSrc;
        logic [1:0] memtoReg;
        logic [1:0] regDst;
        logic [1:0] hiloSel;
        logic       muldivStart;
        logic       illegal;
        logic       usesRs;
        logic       usesRt;
    } ctrl_t;

    localparam logic [3:0] LAT = 4'(MULDIV_LAT);

    ctrl_t             dec;
    logic [REG_AW-1:0] decWreg;
    logic              decRegWrite;
    logic              loadUse;
    logic              mdHazard;
    logic              mdIssue;
    logic [3:0]        mdCnt;

    // Instruction decode; values follow the single-cycle decoder
    always_comb begin
        dec        = '0;
        dec.extOp  = 1'b1;
        dec.usesRs = 1'b1;
        case (OpCode)
            6'h00: begin
                dec.regDst   = 2'b01;
                dec.regWrite = 1'b1;
                dec.usesRt   = 1'b1;
                case (Funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: ;
                    6'h00, 6'h02, 6'h03: begin
                        dec.aluSrc1 = 1'b1;
                        dec.usesRs  = 1'b0;
                    end
                    6'h08: begin
                        dec.regWrite = 1'b0;
                        dec.pcSrc    = 2'b10;
                    end
                    6'h09: begin
                        dec.pcSrc    = 2'b10;
                        dec.memtoReg = 2'b10;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (ENABLE_MULDIV) begin
                            dec.regWrite    = 1'b0;
                            dec.muldivStart = 1'b1;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    6'h10, 6'h12: begin
                        if (ENABLE_MULDIV) begin
                            dec.hiloSel = (Funct == 6'h10) ? 2'b01 : 2'b10;
                            dec.usesRs  = 1'b0;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h23, 6'h24: begin
                dec.regWrite = 1'b1;
                dec.memRead  = 1'b1;
                dec.memtoReg = 2'b01;
                dec.aluSrc2  = 1'b1;
                dec.lbOp     = (OpCode == 6'h24);
            end
            6'h2b: begin
                dec.memWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.usesRt   = 1'b1;
            end
            6'h0f: begin
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.luOp     = 1'b1;
                dec.usesRs   = 1'b0;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
            end
            6'h0c, 6'h0d: begin
                dec.regWrite = 1'b1;
                dec.aluSrc2  = 1'b1;
                dec.extOp    = 1'b0;
            end
            6'h04, 6'h05: begin
                dec.branch  = 1'b1;
                dec.equalOp = (OpCode == 6'h04);
                dec.usesRt  = 1'b1;
            end
            6'h02: begin
                dec.pcSrc  = 2'b01;
                dec.usesRs = 1'b0;
            end
            6'h03: begin
                dec.pcSrc    = 2'b01;
                dec.regWrite = 1'b1;
                dec.regDst   = 2'b10;
                dec.memtoReg = 2'b10;
                dec.usesRs   = 1'b0;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal instruction carries no side effects at all
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Destination resolution; writes to $0 are dropped here
    always_comb begin
        case (dec.regDst)
            2'b00:   decWreg = rt;
            2'b01:   decWreg = rd;
            2'b10:   decWreg = REG_AW'(31);
            default: decWreg = '0;
        endcase
        if (dec.illegal) decWreg = '0;
        decRegWrite = dec.regWrite & (decWreg != '0);
    end

    // Hazard detection; a taken flush overrides any stall
    always_comb begin
        loadUse  = id_valid & ex_valid & ex_MemRead & (ex_wreg != '0) &
                   ((dec.usesRs & (rs == ex_wreg)) | (dec.usesRt & (rt == ex_wreg)));
        mdHazard = id_valid & muldiv_busy & (dec.muldivStart | (dec.hiloSel != 2'b00));
        stall    = (loadUse | mdHazard) & ~flush;
        mdIssue  = id_valid & ~flush & ~stall & dec.muldivStart;
    end

    assign muldiv_busy = (mdCnt != 4'd0);

    // ID/EX control register: bubble on flush, stall or empty ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush || stall || !id_valid) begin
            ex_valid        <= 1'b0;
            ex_RegWrite     <= 1'b0;
            ex_MemRead      <= 1'b0;
            ex_MemWrite     <= 1'b0;
            ex_ALUSrc1      <= 1'b0;
            ex_ALUSrc2      <= 1'b0;
            ex_ExtOp        <= 1'b0;
            ex_LuOp         <= 1'b0;
            ex_LbOp         <= 1'b0;
            ex_Branch       <= 1'b0;
            ex_EqualOp      <= 1'b0;
            ex_PCSrc        <= 2'b00;
            ex_MemtoReg     <= 2'b00;
            ex_wreg         <= '0;
            ex_muldiv_start <= 1'b0;
            ex_hilo_sel     <= 2'b00;
            ex_illegal      <= 1'b0;
        end else begin
            ex_valid        <= 1'b1;
            ex_RegWrite     <= decRegWrite;
            ex_MemRead      <= dec.memRead;
            ex_MemWrite     <= dec.memWrite;
            ex_ALUSrc1      <= dec.aluSrc1;
            ex_ALUSrc2      <= dec.aluSrc2;
            ex_ExtOp        <= dec.extOp;
            ex_LuOp         <= dec.luOp;
            ex_LbOp         <= dec.lbOp;
            ex_Branch       <= dec.branch;
            ex_EqualOp      <= dec.equalOp;
            ex_PCSrc        <= dec.pcSrc;
            ex_MemtoReg     <= dec.memtoReg;
            ex_wreg         <= decWreg;
            ex_muldiv_start <= dec.muldivStart;
            ex_hilo_sel     <= dec.hiloSel;
            ex_illegal      <= dec.illegal;
        end
    end

    // Mult/div busy counter; an issued op keeps counting through a later flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              mdCnt <= 4'd0;
        else if (mdIssue)       mdCnt <= LAT;
        else if (mdCnt != 4'd0) mdCnt <= mdCnt - 4'd1;
    end

endmodule
